// File: rtl/fft_r2_bfly_stage.sv
// First radix-2 DIF butterfly stage with NUM parallel complex lanes.
// The first half of each frame is parked in a half-frame buffer. Each
// second-half beat is combined with its buffered partner to produce
// a+b and a-b at full precision.
// Optional macro FFT_BFLY_PIPE_EN adds a second output register stage,
// giving 2-cycle latency instead of 1.
`timescale 1ns/1ps
module fft_r2_bfly_stage #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16,
  parameter int DATA      = 512
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM-1:0][IN_WIDTH-1:0]       din_i,
  input  logic [NUM-1:0][IN_WIDTH-1:0]       din_q,
  input  logic                               valid_in,
  output logic [NUM-1:0][OUT_WIDTH-1:0]      do1_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]      do1_im,
  output logic [NUM-1:0][OUT_WIDTH-1:0]      do2_re,
  output logic [NUM-1:0][OUT_WIDTH-1:0]      do2_im,
  output logic                               valid_out
);

  localparam int BEATS = DATA / NUM;
  localparam int HALF  = BEATS / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(BEATS - 1);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);

  // Sign-extend one input component to the output width; OUT_WIDTH > IN_WIDTH
  // guarantees the add/sub below can never overflow.
  function automatic logic signed [OUT_WIDTH-1:0] sext(input logic [IN_WIDTH-1:0] x);
    return {{(OUT_WIDTH - IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_half;
  logic          bfly_go;
  logic [AW-1:0] wr_addr, rd_addr;

  // Half-frame buffer, not reset: contents are always written before being read.
  logic [NUM-1:0][IN_WIDTH-1:0] hb_re_q [HALF];
  logic [NUM-1:0][IN_WIDTH-1:0] hb_im_q [HALF];

  logic [NUM-1:0][OUT_WIDTH-1:0] sum_re_p0, sum_im_p0, dif_re_p0, dif_im_p0;
  logic [NUM-1:0][OUT_WIDTH-1:0] sum_re_p1_q, sum_im_p1_q, dif_re_p1_q, dif_im_p1_q;
  logic                          vld_p1_q;

  // Beat counter next state, buffer addressing and the per-lane butterfly.
  always_comb begin
    cnt_d      = cnt_q;
    first_half = (cnt_q < HALF_C);
    bfly_go    = valid_in && !first_half;
    wr_addr    = AW'(cnt_q);
    rd_addr    = AW'(cnt_q - HALF_C);
    if (valid_in) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
    end
    for (int j = 0; j < NUM; j++) begin
      sum_re_p0[j] = sext(hb_re_q[rd_addr][j]) + sext(din_i[j]);
      sum_im_p0[j] = sext(hb_im_q[rd_addr][j]) + sext(din_q[j]);
      dif_re_p0[j] = sext(hb_re_q[rd_addr][j]) - sext(din_i[j]);
      dif_im_p0[j] = sext(hb_im_q[rd_addr][j]) - sext(din_q[j]);
    end
  end

  // Capture first-half beats into the buffer.
  always_ff @(posedge clk) begin
    if (valid_in && first_half) begin
      hb_re_q[wr_addr] <= din_i;
      hb_im_q[wr_addr] <= din_q;
    end
  end

  // ---- stage p0 -> p1: counter, butterfly result register, valid ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      vld_p1_q    <= 1'b0;
      sum_re_p1_q <= '0;
      sum_im_p1_q <= '0;
      dif_re_p1_q <= '0;
      dif_im_p1_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      vld_p1_q <= bfly_go;
      if (bfly_go) begin
        sum_re_p1_q <= sum_re_p0;
        sum_im_p1_q <= sum_im_p0;
        dif_re_p1_q <= dif_re_p0;
        dif_im_p1_q <= dif_im_p0;
      end
    end
  end

`ifdef FFT_BFLY_PIPE_EN
  logic [NUM-1:0][OUT_WIDTH-1:0] sum_re_p2_q, sum_im_p2_q, dif_re_p2_q, dif_im_p2_q;
  logic                          vld_p2_q;

  // ---- stage p1 -> p2: extra output register, holds during gaps ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2_q    <= 1'b0;
      sum_re_p2_q <= '0;
      sum_im_p2_q <= '0;
      dif_re_p2_q <= '0;
      dif_im_p2_q <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        sum_re_p2_q <= sum_re_p1_q;
        sum_im_p2_q <= sum_im_p1_q;
        dif_re_p2_q <= dif_re_p1_q;
        dif_im_p2_q <= dif_im_p1_q;
      end
    end
  end

  assign do1_re    = sum_re_p2_q;
  assign do1_im    = sum_im_p2_q;
  assign do2_re    = dif_re_p2_q;
  assign do2_im    = dif_im_p2_q;
  assign valid_out = vld_p2_q;
`else
  assign do1_re    = sum_re_p1_q;
  assign do1_im    = sum_im_p1_q;
  assign do2_re    = dif_re_p1_q;
  assign do2_im    = dif_im_p1_q;
  assign valid_out = vld_p1_q;
`endif

endmodule

// File: tb/tb_fft_r2_bfly_stage.sv
// Self-checking bench for fft_r2_bfly_stage: frames are driven beat by beat,
// expected butterfly results are pushed to a scoreboard queue at drive time
// and popped when valid_out is seen. Define FFT_BFLY_PIPE_EN to check the
// 2-cycle latency build.
`timescale 1ns/1ps
module tb_fft_r2_bfly_stage;

  localparam int IW    = 9;
  localparam int OW    = 10;
  localparam int NUM   = 16;
  localparam int DATA  = 512;
  localparam int BEATS = DATA / NUM;
  localparam int HB    = BEATS / 2;
  localparam int HN    = DATA / 2;
`ifdef FFT_BFLY_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                     clk = 1'b0;
  logic                     rstn;
  logic [NUM-1:0][IW-1:0]   din_i, din_q;
  logic                     valid_in;
  logic [NUM-1:0][OW-1:0]   do1_re, do1_im, do2_re, do2_im;
  logic                     valid_out;

  fft_r2_bfly_stage #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NUM(NUM), .DATA(DATA)) dut (
    .clk(clk), .rstn(rstn), .din_i(din_i), .din_q(din_q), .valid_in(valid_in),
    .do1_re(do1_re), .do1_im(do1_im), .do2_re(do2_re), .do2_im(do2_im),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                     tag;
    logic [NUM-1:0][OW-1:0] e1r, e1i, e2r, e2i;
  } exp_t;

  typedef struct {
    int ar, ai, br, bi;
    int s_re, s_im, d_re, d_im;
  } vec_t;

  exp_t sbq[$];
  int   fr_re[DATA];
  int   fr_im[DATA];
  int   checks = 0;
  int   errors = 0;
  int   vcount = 0;
  logic [NUM-1:0][OW-1:0] last1r, last1i, last2r, last2i;
  vec_t tab[5];

  task automatic chki(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chkv(input string nm, input logic [NUM*OW-1:0] act, input logic [NUM*OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic clear_last();
    last1r = '0; last1i = '0; last2r = '0; last2i = '0;
  endtask

  // Drive one beat of the current frame; second-half beats push their expectation.
  task automatic drive_beat(input int k, input int t);
    exp_t e;
    for (int j = 0; j < NUM; j++) begin
      din_i[j] = IW'(fr_re[k*NUM+j]);
      din_q[j] = IW'(fr_im[k*NUM+j]);
    end
    valid_in = 1'b1;
    if (k >= HB) begin
      e.tag = cyc + LAT;
      for (int j = 0; j < NUM; j++) begin
        int m;
        m = (k - HB) * NUM + j;
        if (t >= 0) begin
          e.e1r[j] = OW'(tab[t].s_re); e.e1i[j] = OW'(tab[t].s_im);
          e.e2r[j] = OW'(tab[t].d_re); e.e2i[j] = OW'(tab[t].d_im);
        end else begin
          e.e1r[j] = OW'(fr_re[m] + fr_re[m+HN]);
          e.e1i[j] = OW'(fr_im[m] + fr_im[m+HN]);
          e.e2r[j] = OW'(fr_re[m] - fr_re[m+HN]);
          e.e2i[j] = OW'(fr_im[m] - fr_im[m+HN]);
        end
      end
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drive_gap();
    for (int j = 0; j < NUM; j++) begin
      din_i[j] = IW'($urandom);
      din_q[j] = IW'($urandom);
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int nbeats, input bit gaps, input int t);
    for (int k = 0; k < nbeats; k++) begin
      drive_beat(k, t);
      if (gaps) drive_gap();
    end
  endtask

  task automatic drain(input int npulse, input string nm);
    repeat (LAT + 3) @(posedge clk);
    #1;
    chki({nm, "_sb_empty"}, sbq.size(), 0);
    chki({nm, "_pulses"}, vcount, npulse);
    vcount = 0;
  endtask

  task automatic fill_rand();
    for (int n = 0; n < DATA; n++) begin
      fr_re[n] = int'($urandom_range(0, 511)) - 256;
      fr_im[n] = int'($urandom_range(0, 511)) - 256;
    end
  endtask

  task automatic check_zero(input string nm);
    chkv({nm, "_do1_re"}, do1_re, '0);
    chkv({nm, "_do1_im"}, do1_im, '0);
    chkv({nm, "_do2_re"}, do2_re, '0);
    chkv({nm, "_do2_im"}, do2_im, '0);
    chki({nm, "_valid_out"}, int'(valid_out), 0);
  endtask

  initial begin
    tab[0] = '{ 255, -256,  255, -256,  510, -512,    0,    0};
    tab[1] = '{-256,  255,  255, -256,   -1,   -1, -511,  511};
    tab[2] = '{-256, -256, -256, -256, -512, -512,    0,    0};
    tab[3] = '{ 100,   -7,  -20,    3,   80,   -4,  120,  -10};
    tab[4] = '{   0,    0,  255,  255,  255,  255, -255, -255};

    rstn = 1'b1; valid_in = 1'b0; din_i = '0; din_q = '0;
    clear_last();

    // Output monitor: scoreboard pop on valid_out, hold check otherwise.
    fork
      forever begin
        @(negedge clk);
        if (rstn) begin
          if (valid_out) begin
            vcount++;
            if (sbq.size() == 0) begin
              chki("unexpected_valid", int'(valid_out), 0);
            end else begin
              exp_t e;
              e = sbq.pop_front();
              chki("latency", cyc, e.tag);
              chkv("do1_re", do1_re, e.e1r);
              chkv("do1_im", do1_im, e.e1i);
              chkv("do2_re", do2_re, e.e2r);
              chkv("do2_im", do2_im, e.e2i);
            end
            last1r = do1_re; last1i = do1_im; last2r = do2_re; last2i = do2_im;
          end else begin
            if (sbq.size() > 0 && sbq[0].tag <= cyc) begin
              chki("missing_valid", int'(valid_out), 1);
              void'(sbq.pop_front());
            end
            chkv("hold_do1_re", do1_re, last1r);
            chkv("hold_do1_im", do1_im, last1i);
            chkv("hold_do2_re", do2_re, last2r);
            chkv("hold_do2_im", do2_im, last2i);
          end
        end
      end
    join_none

    // Reset with no clock edge in between: outputs must clear asynchronously.
    #2 rstn = 1'b0;
    #1 check_zero("rst_init");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Impulse at sample 0.
    for (int n = 0; n < DATA; n++) begin fr_re[n] = 0; fr_im[n] = 0; end
    fr_re[0] = 5; fr_im[0] = -3;
    run_frame(BEATS, 1'b0, -1);
    drain(HB, "impulse");

    // Ramp frame followed back-to-back by a random frame.
    for (int n = 0; n < DATA; n++) begin fr_re[n] = (n % 256) - 128; fr_im[n] = 0; end
    run_frame(BEATS, 1'b0, -1);
    fill_rand();
    run_frame(BEATS, 1'b0, -1);
    drain(2 * HB, "ramp_b2b");

    // Asynchronous reset mid-cycle while outputs hold nonzero data.
    @(negedge clk); #1;
    rstn = 1'b0;
    clear_last();
    #1 check_zero("rst_async");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Extreme/table vectors: a fills the first half, b the second half.
    for (int t = 0; t < 5; t++) begin
      for (int n = 0; n < DATA; n++) begin
        fr_re[n] = (n < HN) ? tab[t].ar : tab[t].br;
        fr_im[n] = (n < HN) ? tab[t].ai : tab[t].bi;
      end
      run_frame(BEATS, 1'b0, t);
    end
    drain(5 * HB, "table");

    // Same random frame continuous, then with alternate-cycle gaps.
    fill_rand();
    run_frame(BEATS, 1'b0, -1);
    run_frame(BEATS, 1'b1, -1);
    drain(2 * HB, "gaps");

    // Reset after 10 first-half beats; the next frame must start fresh.
    fill_rand();
    run_frame(10, 1'b0, -1);
    @(negedge clk);
    rstn = 1'b0;
    clear_last();
    @(posedge clk); #1;
    chki("rst_mid_valid_out", int'(valid_out), 0);
    rstn = 1'b1;
    fill_rand();
    run_frame(BEATS, 1'b0, -1);
    drain(HB, "mid_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
